// File: rtl/mips_pkg.sv
// Shared definitions for the multicycle MIPS control unit: state codes, opcodes,
// ALU-control classes, datapath mux selects and the control-strobe bundle.
package mips_pkg;

    localparam int unsigned STATE_W = 4;
    localparam int unsigned OPCODE_W = 6;
    localparam int unsigned WAIT_W = 4;

    typedef enum logic [STATE_W-1:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXEC    = 4'd6,
        S_RTYPEWB = 4'd7,
        S_BRANCH  = 4'd8,
        S_JUMP    = 4'd9,
        S_ADDIEX  = 4'd10,
        S_ADDIWB  = 4'd11
    } state_t;

    localparam logic [OPCODE_W-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OPCODE_W-1:0] OP_LW    = 6'b100011;
    localparam logic [OPCODE_W-1:0] OP_SW    = 6'b101011;
    localparam logic [OPCODE_W-1:0] OP_BEQ   = 6'b000100;
    localparam logic [OPCODE_W-1:0] OP_J     = 6'b000010;
    localparam logic [OPCODE_W-1:0] OP_ADDI  = 6'b001000;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_REG  = 2'b00;
    localparam logic [1:0] SRCB_FOUR = 2'b01;
    localparam logic [1:0] SRCB_IMM  = 2'b10;
    localparam logic [1:0] SRCB_BOFS = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       ior_d;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       ir_write;
        logic       reg_write;
        logic       reg_dst;
        logic       alu_src_a;
        logic [1:0] pc_source;
        logic [1:0] alu_op;
        logic [1:0] alu_src_b;
    } ctrl_t;

endpackage

// File: rtl/multicycle_control_wait.sv
// Memory wait counter: counts cycles spent in a waiting state; done when the
// count has reached MEM_WAIT.
module mem_wait_counter #(
    parameter int unsigned WAIT_W   = 4,
    parameter int unsigned MEM_WAIT = 0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic done
);

    logic [WAIT_W-1:0] count_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (clear) begin
            count_q <= '0;
        end else if (enable) begin
            count_q <= count_q + WAIT_W'(1);
        end
    end

    assign done = (count_q == WAIT_W'(MEM_WAIT));

endmodule

// File: rtl/multicycle_control.sv
// Moore control FSM for a multicycle MIPS datapath (lw, sw, R-type, beq, j, addi)
// with a configurable number of extra wait cycles per memory access.
module multicycle_control
    import mips_pkg::*;
#(
    parameter int unsigned MEM_WAIT = 0
) (
    input  logic                Clock,
    input  logic                Reset,
    input  logic [OPCODE_W-1:0] Opcode,
    output logic                PCWrite,
    output logic                PCWriteCond,
    output logic                IorD,
    output logic                MemRead,
    output logic                MemWrite,
    output logic                MemtoReg,
    output logic                IRWrite,
    output logic                RegWrite,
    output logic                RegDst,
    output logic                ALUSrcA,
    output logic [1:0]          PCSource,
    output logic [1:0]          ALUOp,
    output logic [1:0]          ALUSrcB,
    output logic                Illegal,
    output logic [STATE_W-1:0]  State
);

    state_t state_q;
    state_t state_d;
    logic   is_load_q;
    logic   wait_done;
    logic   illegal;
    ctrl_t  ctrl;

    // Any state change clears the counter, so each wait state starts at count 0.
    mem_wait_counter #(
        .WAIT_W   (WAIT_W),
        .MEM_WAIT (MEM_WAIT)
    ) u_wait (
        .clk    (Clock),
        .rst_n  (Reset),
        .clear  (state_d != state_q),
        .enable (state_d == state_q),
        .done   (wait_done)
    );

    // lw/sw choice is captured in DECODE so MEMADR does not re-read Opcode.
    always_ff @(posedge Clock) begin
        if (!Reset) begin
            state_q   <= S_FETCH;
            is_load_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == S_DECODE) begin
                is_load_q <= (Opcode == OP_LW);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        ctrl    = '0;
        illegal = 1'b0;
        case (state_q)
            S_FETCH: begin
                ctrl.mem_read  = 1'b1;
                ctrl.alu_src_b = SRCB_FOUR;
                ctrl.alu_op    = ALUOP_ADD;
                ctrl.pc_source = PCSRC_ALU;
                if (wait_done) begin
                    ctrl.ir_write = 1'b1;
                    ctrl.pc_write = 1'b1;
                    state_d       = S_DECODE;
                end
            end
            S_DECODE: begin
                ctrl.alu_src_b = SRCB_BOFS;
                ctrl.alu_op    = ALUOP_ADD;
                case (Opcode)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_EXEC;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_J:         state_d = S_JUMP;
                    OP_ADDI:      state_d = S_ADDIEX;
                    default: begin
                        illegal = 1'b1;
                        state_d = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALUOP_ADD;
                state_d        = is_load_q ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                ctrl.mem_read = 1'b1;
                ctrl.ior_d    = 1'b1;
                if (wait_done) state_d = S_MEMWB;
            end
            S_MEMWB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b1;
                state_d         = S_FETCH;
            end
            S_MEMWR: begin
                ctrl.mem_write = 1'b1;
                ctrl.ior_d     = 1'b1;
                if (wait_done) state_d = S_FETCH;
            end
            S_EXEC: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_REG;
                ctrl.alu_op    = ALUOP_FUNCT;
                state_d        = S_RTYPEWB;
            end
            S_RTYPEWB: begin
                ctrl.reg_write = 1'b1;
                ctrl.reg_dst   = 1'b1;
                state_d        = S_FETCH;
            end
            S_BRANCH: begin
                ctrl.alu_src_a     = 1'b1;
                ctrl.alu_src_b     = SRCB_REG;
                ctrl.alu_op        = ALUOP_SUB;
                ctrl.pc_write_cond = 1'b1;
                ctrl.pc_source     = PCSRC_ALUOUT;
                state_d            = S_FETCH;
            end
            S_JUMP: begin
                ctrl.pc_write  = 1'b1;
                ctrl.pc_source = PCSRC_JUMP;
                state_d        = S_FETCH;
            end
            S_ADDIEX: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALUOP_ADD;
                state_d        = S_ADDIWB;
            end
            S_ADDIWB: begin
                ctrl.reg_write = 1'b1;
                state_d        = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase
    end

    // Reset holds every strobe low so nothing in the datapath is written.
    assign PCWrite     = Reset & ctrl.pc_write;
    assign PCWriteCond = Reset & ctrl.pc_write_cond;
    assign IorD        = Reset & ctrl.ior_d;
    assign MemRead     = Reset & ctrl.mem_read;
    assign MemWrite    = Reset & ctrl.mem_write;
    assign MemtoReg    = Reset & ctrl.mem_to_reg;
    assign IRWrite     = Reset & ctrl.ir_write;
    assign RegWrite    = Reset & ctrl.reg_write;
    assign RegDst      = Reset & ctrl.reg_dst;
    assign ALUSrcA     = Reset & ctrl.alu_src_a;
    assign PCSource    = Reset ? ctrl.pc_source : 2'b00;
    assign ALUOp       = Reset ? ctrl.alu_op : 2'b00;
    assign ALUSrcB     = Reset ? ctrl.alu_src_b : 2'b00;
    assign Illegal     = Reset & illegal;
    assign State       = Reset ? STATE_W'(state_q) : '0;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed scoreboard bench for multicycle_control: three instances with
// MEM_WAIT = 0, 2 and 3, every output compared once per cycle.
module tb_multicycle_control;

    logic        clk;
    logic        rst [3];
    logic [5:0]  op  [3];
    logic [20:0] obs [3];

    logic [20:0] sb [$];
    int          errors;
    int          checks;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        logic       pcw, pcwc, iord, mr, mw, m2r, irw, rw, rd, asa, ill;
        logic [1:0] pcs, aop, asb;
        logic [3:0] st;

        multicycle_control #(.MEM_WAIT((g == 0) ? 0 : g + 1)) u_dut (
            .Clock       (clk),
            .Reset       (rst[g]),
            .Opcode      (op[g]),
            .PCWrite     (pcw),
            .PCWriteCond (pcwc),
            .IorD        (iord),
            .MemRead     (mr),
            .MemWrite    (mw),
            .MemtoReg    (m2r),
            .IRWrite     (irw),
            .RegWrite    (rw),
            .RegDst      (rd),
            .ALUSrcA     (asa),
            .PCSource    (pcs),
            .ALUOp       (aop),
            .ALUSrcB     (asb),
            .Illegal     (ill),
            .State       (st)
        );

        assign obs[g] = {st, pcw, pcwc, iord, mr, mw, m2r, irw, rw, rd, asa, pcs, aop, asb, ill};
    end

    // Expected output vector for a state, straight from the control table.
    function automatic logic [20:0] ev(input int st, input bit fin, input bit ill);
        logic       pcw, pcwc, iord, mr, mw, m2r, irw, rw, rd, asa;
        logic [1:0] pcs, aop, asb;
        {pcw, pcwc, iord, mr, mw, m2r, irw, rw, rd, asa} = '0;
        pcs = 2'b00; aop = 2'b00; asb = 2'b00;
        case (st)
            0:  begin mr = 1; asb = 2'b01; irw = fin; pcw = fin; end
            1:  asb = 2'b11;
            2:  begin asa = 1; asb = 2'b10; end
            3:  begin mr = 1; iord = 1; end
            4:  begin rw = 1; m2r = 1; end
            5:  begin mw = 1; iord = 1; end
            6:  begin asa = 1; aop = 2'b10; end
            7:  begin rw = 1; rd = 1; end
            8:  begin asa = 1; aop = 2'b01; pcwc = 1; pcs = 2'b01; end
            9:  begin pcw = 1; pcs = 2'b10; end
            10: begin asa = 1; asb = 2'b10; end
            11: rw = 1;
            default: ;
        endcase
        return {4'(st), pcw, pcwc, iord, mr, mw, m2r, irw, rw, rd, asa, pcs, aop, asb, ill};
    endfunction

    task automatic push(input int st, input bit fin, input bit ill);
        sb.push_back(ev(st, fin, ill));
    endtask

    task automatic chk(input int idx, input string tag);
        logic [20:0] exp;
        exp = (sb.size() > 0) ? sb.pop_front() : 21'h1fffff;
        checks++;
        assert (obs[idx] === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs[idx], exp);
        end
    endtask

    // Compare n queued cycles; inputs change just after each rising edge.
    task automatic run(input int idx, input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            chk(idx, tag);
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        for (int i = 0; i < 3; i++) begin
            rst[i] = 1'b0;
            op[i]  = 6'b000000;
        end
        @(posedge clk);
        #1;

        sb.push_back(21'h0); sb.push_back(21'h0);
        run(0, 2, "reset_w0");
        sb.push_back(21'h0); run(1, 1, "reset_w2");
        sb.push_back(21'h0); run(2, 1, "reset_w3");

        rst[0] = 1'b1;
        op[0]  = 6'b100011;
        push(0, 1, 0); push(1, 0, 0); push(2, 0, 0); push(3, 0, 0); push(4, 0, 0);
        run(0, 5, "lw_w0");
        op[0] = 6'b000000;
        push(0, 1, 0); push(1, 0, 0); push(6, 0, 0); push(7, 0, 0);
        run(0, 4, "rtype_w0");
        op[0] = 6'b000100;
        push(0, 1, 0); push(1, 0, 0); push(8, 0, 0);
        run(0, 3, "beq_w0");
        op[0] = 6'b000010;
        push(0, 1, 0); push(1, 0, 0); push(9, 0, 0);
        run(0, 3, "j_w0");
        op[0] = 6'b001000;
        push(0, 1, 0); push(1, 0, 0); push(10, 0, 0); push(11, 0, 0);
        run(0, 4, "addi_w0");
        op[0] = 6'b111111;
        push(0, 1, 0); push(1, 0, 1);
        run(0, 2, "illegal_w0");
        op[0] = 6'b000000;
        push(0, 1, 0);
        run(0, 1, "illegal_next_fetch");

        rst[1] = 1'b1;
        op[1]  = 6'b101011;
        push(0, 0, 0); push(0, 0, 0); push(0, 1, 0); push(1, 0, 0); push(2, 0, 0);
        push(5, 0, 0); push(5, 0, 0); push(5, 0, 0); push(0, 0, 0);
        run(1, 9, "sw_w2");

        rst[2] = 1'b1;
        op[2]  = 6'b100011;
        push(0, 0, 0); push(0, 0, 0); push(0, 0, 0); push(0, 1, 0);
        push(1, 0, 0); push(2, 0, 0); push(3, 0, 0);
        run(2, 7, "lw_w3");
        // Second MEMRD wait cycle, then reset asserted mid-cycle.
        @(negedge clk);
        push(3, 0, 0); chk(2, "memrd_wait1");
        rst[2] = 1'b0;
        #1;
        sb.push_back(21'h0); chk(2, "reset_midwait");
        @(posedge clk);
        #1;
        rst[2] = 1'b1;
        op[2]  = 6'b000010;
        push(0, 0, 0); push(0, 0, 0); push(0, 0, 0); push(0, 1, 0);
        push(1, 0, 0); push(9, 0, 0); push(0, 0, 0);
        run(2, 7, "after_reset_w3");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 SHALL have parameter MEM_WAIT, default 0, meaning extra wait cycles per memory access (range 0..15).
REQ-002 SHALL have port Clock  input  1  single system clock, all state updates on rising edge.
REQ-003 SHALL have port Reset  input  1  synchronous, active-low reset.
REQ-004 SHALL have port Opcode  input  6  instruction bits [31:26] from the instruction register.
REQ-005 SHALL have ports PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite, RegWrite, RegDst, ALUSrcA  output  1 each  datapath strobes/selects.
REQ-006 SHALL have ports PCSource, ALUOp, ALUSrcB  output  2 each  datapath mux selects and ALU-control class.
REQ-007 SHALL have port Illegal  output  1  one-cycle pulse on an unsupported opcode.
REQ-008 SHALL have port State  output  4  current state code, for debug.

Function
REQ-009 SHALL implement a Moore FSM; outputs depend only on state and wait counter; unlisted outputs are 0.
REQ-010 SHALL use the state codes FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, RTYPEWB=7, BRANCH=8, JUMP=9, ADDIEX=10, ADDIWB=11.
REQ-011 SHALL drive these outputs in FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00; IRWrite=1 and PCWrite=1 only in the final wait cycle.
REQ-012 SHALL drive these outputs in DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=00. Opcode is sampled only here.
REQ-013 SHALL branch from DECODE by Opcode: 100011 or 101011 -> MEMADR; 000000 -> EXEC; 000100 -> BRANCH; 000010 -> JUMP; 001000 -> ADDIEX; any other -> FETCH with Illegal=1 during the DECODE cycle.
REQ-014 SHALL drive these outputs in MEMADR: ALUSrcA=1, ALUSrcB=10, ALUOp=00; next state is MEMRD for lw (100011) and MEMWR for sw.
REQ-015 SHALL drive these outputs in MEMRD: MemRead=1, IorD=1; next state is MEMWB after the wait expires.
REQ-016 SHALL drive these outputs in MEMWB: RegWrite=1, MemtoReg=1, RegDst=0; next state is FETCH.
REQ-017 SHALL drive these outputs in MEMWR: MemWrite=1 (held every wait cycle), IorD=1; next state is FETCH after the wait expires.
REQ-018 SHALL drive these outputs in EXEC: ALUSrcA=1, ALUSrcB=00, ALUOp=10; next state is RTYPEWB. RTYPEWB drives RegWrite=1, RegDst=1, MemtoReg=0; next state is FETCH.
REQ-019 SHALL drive these outputs in BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01; next state is FETCH.
REQ-020 SHALL drive these outputs in JUMP: PCWrite=1, PCSource=10; next state is FETCH.
REQ-021 SHALL drive these outputs in ADDIEX: ALUSrcA=1, ALUSrcB=10, ALUOp=00; next state is ADDIWB. ADDIWB drives RegWrite=1, RegDst=0, MemtoReg=0; next state is FETCH.
REQ-022 SHALL have a 4-bit wait counter: cleared on entry to FETCH/MEMRD/MEMWR; stay in the state while counter < MEM_WAIT; leave when counter == MEM_WAIT.
REQ-023 SHALL take total cycles per instruction of: beq/j 3, R/addi/sw 4, lw 5; add MEM_WAIT for fetch, plus MEM_WAIT again for lw/sw.
REQ-024 SHALL assert RegWrite for exactly one cycle per R/addi/lw instruction and never for sw/beq/j/illegal.
REQ-025 SHALL never assert MemRead and MemWrite in the same cycle.

Reset
REQ-026 SHALL, on a rising edge with Reset=0, set state to FETCH and clear the wait counter, regardless of the current state (including mid-wait).
REQ-027 SHALL force every output to 0 while Reset=0, so no PC, IR, register or memory write occurs; State reads 0.
REQ-028 SHALL start FETCH wait cycle 0 on the first edge after Reset returns to 1.

Structure
REQ-029 SHALL place the state codes, opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI) and ALUOp codes in the shared package mips_pkg.
REQ-030 SHALL implement the wait counter as the one sub-module mem_wait_counter (clear, enable, done == count reached MEM_WAIT).

Verification
REQ-031 SHALL cover: Reset=0 for 2 cycles, then release -> all outputs 0 during reset; next cycle State=0, MemRead=1, IRWrite=1, PCWrite=1.
REQ-032 SHALL cover: MEM_WAIT=0, Opcode=100011 -> states 0,1,2,3,4,0; RegWrite=1 only in state 4 with MemtoReg=1.
REQ-033 SHALL cover: MEM_WAIT=2, Opcode=101011 -> FETCH held 3 cycles with IRWrite only on the 3rd; MEMWR held 3 cycles; 8 cycles total; RegWrite never 1.
REQ-034 SHALL cover: Opcode=000000, then 000100, then 000010 -> 4, 3, 3 cycles; ALUOp=10 in EXEC; PCWriteCond=1 with PCSource=01; PCWrite=1 with PCSource=10.
REQ-035 SHALL cover: Opcode=111111 -> Illegal=1 for one cycle in DECODE, then FETCH, with no RegWrite/MemWrite.
REQ-036 SHALL cover: Reset=0 asserted in MEMRD with MEM_WAIT=3 at wait count 1 -> next state FETCH, counter 0, no RegWrite afterward.
